// File: rtl/vga_pkg.sv
// Constants and types shared by the VGA adapter, address translator and rect filler.
package vga_pkg;

  localparam int X_WIDTH      = 9;
  localparam int Y_WIDTH      = 8;
  localparam int COLOUR_WIDTH = 3;
  localparam int X_MAX        = 320;
  localparam int Y_MAX        = 240;

  typedef enum logic [1:0] {IDLE, FILL, FINISH} rect_state_t;

  typedef logic [COLOUR_WIDTH-1:0] colour_t;

endpackage

// File: rtl/vga_rect_clip.sv
// Clips a rectangle to the screen: exclusive end column/row plus an empty flag.
module vga_rect_clip
  import vga_pkg::*;
(
  input  logic [X_WIDTH-1:0] x0,
  input  logic [Y_WIDTH-1:0] y0,
  input  logic [X_WIDTH-1:0] w,
  input  logic [Y_WIDTH-1:0] h,
  output logic [X_WIDTH:0]   x_end,
  output logic [Y_WIDTH:0]   y_end,
  output logic               empty
);

  localparam logic [X_WIDTH:0] X_LIM = (X_WIDTH+1)'(X_MAX);
  localparam logic [Y_WIDTH:0] Y_LIM = (Y_WIDTH+1)'(Y_MAX);

  logic [X_WIDTH:0] x_sum;
  logic [Y_WIDTH:0] y_sum;

  // One extra bit so origin + size never wraps before the min.
  assign x_sum = {1'b0, x0} + {1'b0, w};
  assign y_sum = {1'b0, y0} + {1'b0, h};

  assign x_end = (x_sum > X_LIM) ? X_LIM : x_sum;
  assign y_end = (y_sum > Y_LIM) ? Y_LIM : y_sum;
  assign empty = (x_end <= {1'b0, x0}) || (y_end <= {1'b0, y0});

endmodule

// File: rtl/vga_rect_filler.sv
// Row-major rectangle fill, one registered pixel write per clock, clipped to the screen.
// Define VGA_RECT_OUTLINE_EN to add the outline input (border-only plotting).
module vga_rect_filler
  import vga_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [X_WIDTH-1:0] x0,
  input  logic [Y_WIDTH-1:0] y0,
  input  logic [X_WIDTH-1:0] w,
  input  logic [Y_WIDTH-1:0] h,
  input  colour_t            colour_in,
`ifdef VGA_RECT_OUTLINE_EN
  input  logic               outline,
`endif
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output colour_t            colour,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  rect_state_t        state, state_d;
  logic [X_WIDTH-1:0] cx, cx_d, x_org;
  logic [Y_WIDTH-1:0] cy, cy_d;
  logic [X_WIDTH:0]   x_end, x_lim;
  logic [Y_WIDTH:0]   y_end, y_lim;
  logic               empty, accept, cx_last, cy_last, border;
  logic               scan_d, plot_d, busy_d, done_d;
  colour_t            col_q, colour_r;

  vga_rect_clip u_clip (
    .x0    (x0),
    .y0    (y0),
    .w     (w),
    .h     (h),
    .x_end (x_end),
    .y_end (y_end),
    .empty (empty)
  );

  assign accept   = (state == IDLE) && start;
  assign colour_r = accept ? colour_in : col_q;
  assign cx_last  = ({1'b0, cx} + (X_WIDTH+1)'(1)) == x_lim;
  assign cy_last  = ({1'b0, cy} + (Y_WIDTH+1)'(1)) == y_lim;

`ifdef VGA_RECT_OUTLINE_EN
  logic [Y_WIDTH-1:0] y_org;
  logic               outl_q;
  logic [X_WIDTH-1:0] xo_r;
  logic [Y_WIDTH-1:0] yo_r;
  logic [X_WIDTH:0]   xl_r;
  logic [Y_WIDTH:0]   yl_r;
  logic               ol_r;

  // The first pixel is decided in the accepting cycle, before the latches load.
  assign xo_r   = accept ? x0 : x_org;
  assign yo_r   = accept ? y0 : y_org;
  assign xl_r   = accept ? x_end : x_lim;
  assign yl_r   = accept ? y_end : y_lim;
  assign ol_r   = accept ? outline : outl_q;
  assign border = !ol_r || (cx_d == xo_r) || (cy_d == yo_r) ||
                  (({1'b0, cx_d} + (X_WIDTH+1)'(1)) == xl_r) ||
                  (({1'b0, cy_d} + (Y_WIDTH+1)'(1)) == yl_r);
`else
  assign border = 1'b1;
`endif

  always_comb begin
    state_d = state;
    cx_d    = cx;
    cy_d    = cy;
    scan_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (empty) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = FILL;
            cx_d    = x0;
            cy_d    = y0;
            scan_d  = 1'b1;
          end
        end
      end
      FILL: begin
        busy_d = 1'b1;
        if (cx_last && cy_last) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else if (cx_last) begin
          cx_d   = x_org;
          cy_d   = cy + Y_WIDTH'(1);
          scan_d = 1'b1;
        end else begin
          cx_d   = cx + X_WIDTH'(1);
          scan_d = 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    plot_d = scan_d && border;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cx     <= '0;
      cy     <= '0;
      x_org  <= '0;
      x_lim  <= '0;
      y_lim  <= '0;
      col_q  <= '0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef VGA_RECT_OUTLINE_EN
      y_org  <= '0;
      outl_q <= 1'b0;
`endif
    end else begin
      state <= state_d;
      cx    <= cx_d;
      cy    <= cy_d;
      plot  <= plot_d;
      busy  <= busy_d;
      done  <= done_d;
      // Output coordinates only move on a real write; they hold otherwise.
      if (plot_d) begin
        x      <= cx_d;
        y      <= cy_d;
        colour <= colour_r;
      end
      if (accept) begin
        x_org <= x0;
        x_lim <= x_end;
        y_lim <= y_end;
        col_q <= colour_in;
`ifdef VGA_RECT_OUTLINE_EN
        y_org  <= y0;
        outl_q <= outline;
`endif
      end
    end
  end

endmodule

// File: tb/tb_vga_rect_filler.sv
// Directed and random rectangle commands checked cycle by cycle against a scan-order model.
module tb_vga_rect_filler;
  import vga_pkg::*;

  logic               clock = 1'b0;
  logic               reset, start;
  logic [X_WIDTH-1:0] x0, w;
  logic [Y_WIDTH-1:0] y0, h;
  colour_t            colour_in;
  logic [X_WIDTH-1:0] x;
  logic [Y_WIDTH-1:0] y;
  colour_t            colour;
  logic               plot, busy, done;
`ifdef VGA_RECT_OUTLINE_EN
  logic               outline = 1'b0;
`endif

  int n_asrt = 0;
  int n_fail = 0;

  typedef struct {bit p; int x; int y;} step_t;
  step_t exp_q[$];

  vga_rect_filler dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .w         (w),
    .h         (h),
    .colour_in (colour_in),
`ifdef VGA_RECT_OUTLINE_EN
    .outline   (outline),
`endif
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Expected scan: one entry per scan cycle, p = pixel is written.
  task automatic build(input int ax0, input int ay0, input int aw, input int ah, input bit ol);
    int xe, ye;
    xe = ax0 + aw;
    ye = ay0 + ah;
    if (xe > X_MAX) xe = X_MAX;
    if (ye > Y_MAX) ye = Y_MAX;
    exp_q.delete();
    for (int yy = ay0; yy < ye; yy++)
      for (int xx = ax0; xx < xe; xx++)
        exp_q.push_back('{p: (!ol || xx == ax0 || xx == xe - 1 || yy == ay0 || yy == ye - 1),
                          x: xx, y: yy});
  endtask

  // Called at a negedge; returns at the negedge of the cycle after done.
  task automatic run_cmd(input int ax0, input int ay0, input int aw, input int ah,
                         input int col, input bit ol, input bit poke, input string tag);
    int n, busy_n, done_k;
    step_t s;
    build(ax0, ay0, aw, ah, ol);
    n      = exp_q.size();
    busy_n = 0;
    done_k = 0;
    x0 = X_WIDTH'(ax0);
    y0 = Y_WIDTH'(ay0);
    w  = X_WIDTH'(aw);
    h  = Y_WIDTH'(ah);
    colour_in = COLOUR_WIDTH'(col);
`ifdef VGA_RECT_OUTLINE_EN
    outline = ol;
`endif
    start = 1'b1;
    @(negedge clock);
    for (int k = 1; k <= n + 5 && done_k == 0; k++) begin
      if (poke && k == 2 && n >= 2) begin
        start     = 1'b1;
        x0        = X_WIDTH'($urandom);
        y0        = Y_WIDTH'($urandom);
        w         = X_WIDTH'($urandom);
        h         = Y_WIDTH'($urandom);
        colour_in = COLOUR_WIDTH'($urandom);
      end else begin
        start = 1'b0;
      end
      if (k <= n) begin
        s = exp_q[k-1];
        if (s.p)
          check({tag, "_pix"}, {busy, done, plot, x, y, colour},
                {3'b101, X_WIDTH'(s.x), Y_WIDTH'(s.y), COLOUR_WIDTH'(col)});
        else
          check({tag, "_gap"}, {busy, done, plot}, 3'b100);
      end else if (k == n + 1) begin
        check({tag, "_fin"}, {busy, done, plot}, 3'b110);
      end
      if (done) done_k = k;
      if (busy) busy_n++;
      @(negedge clock);
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, done_k, n + 1);
    check({tag, "_busy_cycles"}, busy_n, n + 1);
    check({tag, "_idle_after"}, {busy, done, plot}, 3'b000);
  endtask

  initial begin
    bit ol;
    reset = 1'b1;
    start = 1'b1;
    x0 = 9'd1; y0 = 8'd1; w = 9'd2; h = 8'd2; colour_in = 3'd7;
    repeat (2) @(negedge clock);
    check("reset_state", {x, y, colour, plot, busy, done}, '0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    check("reset_beats_start", {busy, done, plot}, 3'b000);

    run_cmd(10, 20, 3, 2, 3'b101, 1'b0, 1'b0, "basic");
    run_cmd(318, 238, 5, 5, 3'b011, 1'b0, 1'b0, "clip");
    run_cmd(300, 100, 511, 2, 3'b110, 1'b0, 1'b0, "clip_wide");
    run_cmd(5, 5, 0, 4, 3'b001, 1'b0, 1'b0, "empty_w");
    run_cmd(320, 10, 4, 4, 3'b010, 1'b0, 1'b0, "empty_x");
    run_cmd(7, 240, 4, 4, 3'b010, 1'b0, 1'b0, "empty_y");
    run_cmd(100, 50, 5, 3, 3'b011, 1'b0, 1'b1, "poke");
    run_cmd(200, 30, 2, 3, 3'b100, 1'b0, 1'b0, "back_to_back");

    // Reset on the third plot of a 4x4 fill.
    build(50, 60, 4, 4, 1'b0);
    x0 = 9'd50; y0 = 8'd60; w = 9'd4; h = 8'd4; colour_in = 3'b111;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      check("rst_pre_pix", {plot, x, y}, {1'b1, X_WIDTH'(exp_q[k-1].x), Y_WIDTH'(exp_q[k-1].y)});
      if (k == 3) reset = 1'b1;
      @(negedge clock);
    end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("rst_quiet", {busy, done, plot}, 3'b000);
      @(negedge clock);
    end
    run_cmd(50, 60, 4, 4, 3'b111, 1'b0, 1'b0, "after_reset");

`ifdef VGA_RECT_OUTLINE_EN
    run_cmd(0, 0, 4, 4, 3'b110, 1'b1, 1'b0, "outline");
    run_cmd(317, 237, 6, 6, 3'b101, 1'b1, 1'b0, "outline_clip");
`endif

    for (int i = 0; i < 12; i++) begin
`ifdef VGA_RECT_OUTLINE_EN
      ol = 1'($urandom_range(0, 1));
`else
      ol = 1'b0;
`endif
      run_cmd($urandom_range(0, 330), $urandom_range(0, 250), $urandom_range(0, 12),
              $urandom_range(0, 8), $urandom_range(0, 7), ol, (i % 3) == 0, "rnd");
    end

    run_cmd(0, 0, 320, 240, 3'b010, 1'b0, 1'b0, "full_screen");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
